// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_issuer
// Brief   : Command-side initiator for a SimpleALU-style ALU with a 4-entry
//           operand register file, fixed-latency or Ready-based completion.
// Revision: 1.0
// ============================================================================
module alu_op_issuer #(
    parameter int                         INPUT_BIT_WIDTH = 8,
    parameter int                         INSTR_BIT_WIDTH = 5,
    parameter int                         FIXED_LATENCY   = 2,
    parameter int                         DIV_TIMEOUT     = 32,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = 5'b00000,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_DIV  = 5'b00100
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       CmdValid,
    output logic                       CmdReady,
    input  logic [INSTR_BIT_WIDTH-1:0] CmdInstr,
    input  logic [1:0]                 CmdSrcA,
    input  logic [1:0]                 CmdSrcB,
    input  logic [1:0]                 CmdDst,
    input  logic                       LoadValid,
    input  logic [1:0]                 LoadAddr,
    input  logic [INPUT_BIT_WIDTH-1:0] LoadData,
    input  logic [1:0]                 ReadAddr,
    output logic [INPUT_BIT_WIDTH-1:0] ReadData,
    output logic [INSTR_BIT_WIDTH-1:0] AluInstruction,
    output logic [INPUT_BIT_WIDTH-1:0] AluInputA,
    output logic [INPUT_BIT_WIDTH-1:0] AluInputB,
    input  logic [INPUT_BIT_WIDTH-1:0] AluResultA,
    input  logic [INPUT_BIT_WIDTH-1:0] AluResultB,
    input  logic                       AluReady,
    output logic                       DoneValid,
    output logic [INPUT_BIT_WIDTH-1:0] DoneResult,
    output logic                       Busy,
    output logic                       Timeout
);

    localparam logic [8:0] c_fixed_latency = 9'(FIXED_LATENCY);
    localparam logic [8:0] c_div_timeout   = 9'(DIV_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [INPUT_BIT_WIDTH-1:0]   regs_q [4];
    logic [INPUT_BIT_WIDTH-1:0]   regs_d [4];
    logic [INSTR_BIT_WIDTH-1:0]   instr_q, instr_d;
    logic [1:0]                   dst_q, dst_d;
    logic [INPUT_BIT_WIDTH-1:0]   op_a_q, op_a_d;
    logic [INPUT_BIT_WIDTH-1:0]   op_b_q, op_b_d;
    logic [7:0]                   cnt_q, cnt_d;
    logic [INPUT_BIT_WIDTH-1:0]   done_result_q, done_result_d;
    logic                         timeout_q, timeout_d;

    logic                         w_can_accept;
    logic                         w_accept;
    logic                         w_in_flight;
    logic                         w_is_div;
    logic [8:0]                   w_edge_num;
    logic                         w_sample;
    logic                         w_expire;

    always_comb begin
        w_can_accept = (state_q == ST_IDLE) || (state_q == ST_WB);
        w_accept     = CmdValid && w_can_accept;
        w_in_flight  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        w_is_div     = (instr_q == CODE_INSTR_DIV);
        // Ordinal of the edge that ends the current cycle, counted from the accept edge.
        w_edge_num   = {1'b0, cnt_q} + 9'd1;
        w_sample     = 1'b0;
        w_expire     = 1'b0;
        if (w_in_flight) begin
            if (w_is_div) begin
                // Ready at the first post-accept edge may belong to a previous divide.
                w_sample = AluReady && (w_edge_num >= 9'd2);
                w_expire = !w_sample && (w_edge_num >= c_div_timeout);
            end else begin
                w_sample = (w_edge_num == c_fixed_latency);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        regs_d        = regs_q;
        instr_d       = instr_q;
        dst_d         = dst_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        cnt_d         = cnt_q;
        done_result_d = done_result_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE, ST_WB: begin
                state_d = w_accept ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE, ST_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (w_sample || w_expire) ? ST_WB : ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands come from the current register contents, so a same-edge load is not bypassed.
        if (w_accept) begin
            instr_d = CmdInstr;
            dst_d   = CmdDst;
            op_a_d  = regs_q[CmdSrcA];
            op_b_d  = regs_q[CmdSrcB];
            cnt_d   = 8'd0;
        end

        if (LoadValid) begin
            regs_d[LoadAddr] = LoadData;
        end

        if (w_sample) begin
            regs_d[dst_q]  = AluResultA;
            done_result_d  = AluResultA;
            if (w_is_div) begin
                regs_d[dst_q + 2'd1] = AluResultB;
            end
        end

        if (w_expire) begin
            done_result_d = '0;
            timeout_d     = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            instr_q       <= CODE_INSTR_NOP;
            dst_q         <= 2'd0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cnt_q         <= 8'd0;
            done_result_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            instr_q       <= instr_d;
            dst_q         <= dst_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            cnt_q         <= cnt_d;
            done_result_q <= done_result_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        CmdReady       = ResetN && w_can_accept;
        Busy           = w_in_flight;
        DoneValid      = (state_q == ST_WB);
        DoneResult     = done_result_q;
        Timeout        = timeout_q;
        ReadData       = regs_q[ReadAddr];
        AluInstruction = w_in_flight ? instr_q : CODE_INSTR_NOP;
        AluInputA      = w_in_flight ? op_a_q : '0;
        AluInputB      = w_in_flight ? op_b_q : '0;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Command-side initiator for the team's SimpleALU-style ALU. It owns a 4-entry operand register file, accepts ALU commands over a valid/ready handshake, and drives instruction and operands into the ALU. It waits either a fixed latency or, for division, for the ALU Ready signal, then writes results back and reports completion. It sits between the instruction sequencer and the ALU.

Parameters:
INPUT_BIT_WIDTH, 8, data and register width (same as ALU).
INSTR_BIT_WIDTH, 5, instruction code width.
FIXED_LATENCY, 2, edges from issue to result sampling for non-DIV ops; legal range 1..15.
DIV_TIMEOUT, 32, maximum edges to wait for ALU Ready on DIV; legal range 2..255.
CODE_INSTR_NOP, 5'b00000, code driven to the ALU when idle.
CODE_INSTR_DIV, 5'b00100, code that selects the Ready-based wait and dual writeback.

Ports:
Clk  in  1  clock, all state on rising edge.
ResetN  in  1  asynchronous, active-low reset.
CmdValid  in  1  command present.
CmdReady  out  1  issuer can accept a command.
CmdInstr  in  INSTR_BIT_WIDTH  ALU instruction code.
CmdSrcA  in  2  register index for ALU InputA.
CmdSrcB  in  2  register index for ALU InputB.
CmdDst  in  2  destination register index.
LoadValid  in  1  direct register write strobe.
LoadAddr  in  2  register index to load.
LoadData  in  INSTR-independent INPUT_BIT_WIDTH  load value.
ReadAddr  in  2  debug read index.
ReadData  out  INPUT_BIT_WIDTH  combinational register read.
AluInstruction  out  INSTR_BIT_WIDTH  to ALU Instruction.
AluInputA  out  INPUT_BIT_WIDTH  to ALU InputA.
AluInputB  out  INPUT_BIT_WIDTH  to ALU InputB.
AluResultA  in  INPUT_BIT_WIDTH  from ALU ResultA.
AluResultB  in  INPUT_BIT_WIDTH  from ALU ResultB.
AluReady  in  1  from ALU Ready (divider done).
DoneValid  out  1  one-cycle completion pulse.
DoneResult  out  INPUT_BIT_WIDTH  ResultA written, or 0 on timeout.
Busy  out  1  command in flight.
Timeout  out  1  sticky DIV timeout flag.

Behaviour:
- Reset (async, ResetN=0): state IDLE. All registers 0. AluInstruction=CODE_INSTR_NOP. AluInputA/B=0. DoneValid=0, DoneResult=0, Busy=0, Timeout=0. CmdReady=0 while ResetN=0; CmdReady=1 in the first cycle after release.
- Reset mid-operation: the command is abandoned, with no writeback and no DoneValid.
- States:
  - IDLE: CmdReady=1, Busy=0. Accept when CmdValid&&CmdReady at an edge. At that edge, latch the instruction, Dst, and the register values at SrcA/SrcB.
  - ISSUE (1 cycle): drive the latched values to the ALU.
  - WAIT: keep driving the same values.
  - WB: 1 cycle, DoneValid=1. Return to IDLE.
- Outputs per state:
  - Busy=1 in ISSUE and WAIT.
  - CmdReady=0 in ISSUE and WAIT. CmdReady=1 in WB, so back-to-back accept is allowed at the edge ending WB.
  - AluInstruction=NOP in IDLE and WB.
- Non-DIV command:
  - Results are sampled at the FIXED_LATENCY-th edge after the accept edge.
  - AluResultA is written to reg[CmdDst] and to DoneResult.
  - AluResultB is ignored.
- DIV command:
  - AluReady is ignored at the first edge after accept, because it may be stale from a prior op.
  - From the 2nd edge on, the first edge with AluReady=1 samples the results: AluResultA (quotient) goes to reg[Dst] and DoneResult; AluResultB (remainder) goes to reg[(Dst+1) mod 4]. Index 3 wraps to 0.
- DIV timeout:
  - If DIV_TIMEOUT edges after accept pass with no qualifying AluReady, abort the command.
  - No register write. Timeout latches to 1 (cleared only by reset). WB occurs with DoneResult=0.
- Load port:
  - Active in every state. reg[LoadAddr] <= LoadData at the edge.
  - Writeback and load to the same register at the same edge: writeback wins.
  - Load and accept at the same edge: operands capture the pre-load value (no bypass).
- Operands are latched at accept, so later loads do not affect an in-flight op.
- No arithmetic is done in the block. Register indices wrap modulo 4. All datapaths are INPUT_BIT_WIDTH, with no extension.

Test Plan:
- Reset/idle: hold ResetN=0 for 3 cycles, then release → all outputs 0, AluInstruction=NOP, CmdReady=1 in the first post-reset cycle, ReadData=0 for all indices.
- ADD (FIXED_LATENCY=2): load R0=5, R1=3; issue ADD (5'b00001) Src0,Src1,Dst2; ALU model returns A+B → AluInputA=5, AluInputB=3 for 2 cycles; DoneValid pulse 1 cycle with DoneResult=8; R2=8.
- DIV with wrap: R0=17, R1=5; issue DIV Dst3; model asserts AluReady 6 edges later with quotient 3, remainder 2 → R3=3, R0=2, DoneResult=3, Timeout=0.
- DIV stale Ready: AluReady held 1 at the accept edge and the next edge, then low, then high 4 edges later → only the later pulse is accepted.
- DIV timeout: AluReady stuck 0 → at edge 32, DoneValid with DoneResult=0, Timeout=1 and stays 1, registers unchanged; the next command is still accepted.
- Collisions: Load R2=0xAA at the same edge as a writeback to R2=0x08 → R2=0x08. Accept with simultaneous load R0=9 (old R0=5) → AluInputA=5. Assert ResetN=0 mid-WAIT → no DoneValid, R-file=0.
